// File: rtl/coreabc_ram_fifo_ctrl_if.sv
// coreabc_ram_fifo_ctrl_if: client handshake, status and RAM port bundle for the 256x8 FIFO controller.
interface coreabc_ram_fifo_ctrl_if;
    logic       PUSH;
    logic [7:0] PUSH_DATA;
    logic       POP;
    logic [7:0] POP_DATA;
    logic       POP_VALID;
    logic       FULL;
    logic       EMPTY;
    logic       AFULL;
    logic       AEMPTY;
    logic [8:0] COUNT;
    logic       OVERFLOW;
    logic       UNDERFLOW;
    logic       ERR_CLR;
    logic       RAM_WEN;
    logic       RAM_REN;
    logic [7:0] RAM_WADDR;
    logic [7:0] RAM_RADDR;
    logic [7:0] RAM_WD;
    logic [7:0] RAM_RD;

    modport master (
        output PUSH, PUSH_DATA, POP, ERR_CLR,
        input  POP_DATA, POP_VALID, FULL, EMPTY, AFULL, AEMPTY, COUNT, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  PUSH, PUSH_DATA, POP, ERR_CLR, RAM_RD,
        output POP_DATA, POP_VALID, FULL, EMPTY, AFULL, AEMPTY, COUNT, OVERFLOW, UNDERFLOW,
        output RAM_WEN, RAM_REN, RAM_WADDR, RAM_RADDR, RAM_WD
    );
endinterface

// File: rtl/coreabc_ram_fifo_ctrl.sv
// coreabc_ram_fifo_ctrl: 256x8 FIFO controller driving the CoreABC dual-address RAM.
// Define COREABC_FIFO_STICKY_ERR_EN for sticky OVERFLOW/UNDERFLOW cleared by ERR_CLR.
module coreabc_ram_fifo_ctrl #(
    parameter int AFULL_THRESH  = 192,
    parameter int AEMPTY_THRESH = 64
) (
    input logic                    PCLK,
    input logic                    PRESETN,
    coreabc_ram_fifo_ctrl_if.slave bus
);
    localparam logic [8:0] afull_lvl  = 9'(AFULL_THRESH);
    localparam logic [8:0] aempty_lvl = 9'(AEMPTY_THRESH);

    logic [7:0] wptr, rptr;
    logic [8:0] count, count_nxt;
    logic       full, empty, afull, aempty;
    logic       pop_valid, overflow, underflow;
    logic       push_ok, pop_ok, push_rej, pop_rej;

    // Acceptance uses registered flags, so a full FIFO never writes the slot being read
    always_comb begin
        push_ok   = bus.PUSH & ~full;
        pop_ok    = bus.POP & ~empty;
        push_rej  = bus.PUSH & full;
        pop_rej   = bus.POP & empty;
        count_nxt = count + 9'(push_ok) - 9'(pop_ok);
    end

    assign bus.RAM_WEN   = push_ok;
    assign bus.RAM_WADDR = wptr;
    assign bus.RAM_WD    = bus.PUSH_DATA;
    assign bus.RAM_REN   = pop_ok;
    assign bus.RAM_RADDR = rptr;
    assign bus.POP_DATA  = bus.RAM_RD;
    assign bus.POP_VALID = pop_valid;
    assign bus.FULL      = full;
    assign bus.EMPTY     = empty;
    assign bus.AFULL     = afull;
    assign bus.AEMPTY    = aempty;
    assign bus.COUNT     = count;
    assign bus.OVERFLOW  = overflow;
    assign bus.UNDERFLOW = underflow;

`ifndef COREABC_FIFO_STICKY_ERR_EN
    logic unused_err_clr;
    assign unused_err_clr = bus.ERR_CLR;
`endif

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            afull     <= 1'b0;
            aempty    <= 1'b1;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wptr      <= wptr + 8'(push_ok);
            rptr      <= rptr + 8'(pop_ok);
            count     <= count_nxt;
            full      <= count_nxt == 9'd256;
            empty     <= count_nxt == 9'd0;
            afull     <= count_nxt >= afull_lvl;
            aempty    <= count_nxt <= aempty_lvl;
            pop_valid <= pop_ok;
`ifdef COREABC_FIFO_STICKY_ERR_EN
            overflow  <= push_rej | (overflow & ~bus.ERR_CLR);
            underflow <= pop_rej | (underflow & ~bus.ERR_CLR);
`else
            overflow  <= push_rej;
            underflow <= pop_rej;
`endif
        end
    end
endmodule

// File: tb/tb_coreabc_ram_fifo_ctrl.sv
// tb_coreabc_ram_fifo_ctrl: directed and random checks against a queue model, with a behavioural 256x8 RAM.
module tb_coreabc_ram_fifo_ctrl;
    logic clk = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    coreabc_ram_fifo_ctrl_if bus();

    coreabc_ram_fifo_ctrl dut (
        .PCLK(clk),
        .PRESETN(rstn),
        .bus(bus)
    );

    logic [7:0] mem [256];
    logic [7:0] rd_q;
    always @(posedge clk) begin
        if (bus.RAM_WEN) mem[bus.RAM_WADDR] <= bus.RAM_WD;
        if (bus.RAM_REN) rd_q <= mem[bus.RAM_RADDR];
    end
    assign bus.RAM_RD = rd_q;

    int n_tests = 0;
    int n_fail = 0;
    logic [7:0] q[$];
    logic [7:0] last_data;
    bit have_data = 0;
    bit m_valid = 0;
    bit m_ovf = 0;
    bit m_unf = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic post_checks();
        check("count", 32'(bus.COUNT), q.size());
        check("full", 32'(bus.FULL), 32'(q.size() == 256));
        check("empty", 32'(bus.EMPTY), 32'(q.size() == 0));
        check("afull", 32'(bus.AFULL), 32'(q.size() >= 192));
        check("aempty", 32'(bus.AEMPTY), 32'(q.size() <= 64));
        check("pop_valid", 32'(bus.POP_VALID), 32'(m_valid));
        if (have_data) check("pop_data", 32'(bus.POP_DATA), 32'(last_data));
        check("overflow", 32'(bus.OVERFLOW), 32'(m_ovf));
        check("underflow", 32'(bus.UNDERFLOW), 32'(m_unf));
    endtask

    task automatic step(input logic p, input logic [7:0] d, input logic o, input logic c);
        bit pok, ook, pev, oev;
        bus.PUSH = p;
        bus.PUSH_DATA = d;
        bus.POP = o;
        bus.ERR_CLR = c;
        #1;
        pok = p && q.size() < 256;
        ook = o && q.size() > 0;
        pev = p && !pok;
        oev = o && !ook;
        check("ram_wen", 32'(bus.RAM_WEN), 32'(pok));
        check("ram_ren", 32'(bus.RAM_REN), 32'(ook));
        if (pok) check("ram_wd", 32'(bus.RAM_WD), 32'(d));
        @(posedge clk);
        #1;
        if (ook) begin
            last_data = q.pop_front();
            have_data = 1;
        end
        if (pok) q.push_back(d);
        m_valid = ook;
`ifdef COREABC_FIFO_STICKY_ERR_EN
        m_ovf = pev || (m_ovf && !c);
        m_unf = oev || (m_unf && !c);
`else
        m_ovf = pev;
        m_unf = oev;
`endif
        post_checks();
    endtask

    task automatic reset_step(input logic p, input logic o);
        rstn = 1'b0;
        bus.PUSH = p;
        bus.PUSH_DATA = 8'hEE;
        bus.POP = o;
        bus.ERR_CLR = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        q.delete();
        have_data = 0;
        m_valid = 0;
        m_ovf = 0;
        m_unf = 0;
        post_checks();
    endtask

    task automatic drain();
        while (q.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        bus.PUSH = 1'b0;
        bus.PUSH_DATA = 8'h00;
        bus.POP = 1'b0;
        bus.ERR_CLR = 1'b0;
        @(posedge clk);
        #1;
        reset_step(1'b0, 1'b0);
        reset_step(1'b0, 1'b0);
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        drain();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
        while (q.size() < 256) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        drain();
        step(1'b1, 8'hC3, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45),
                 1'($urandom_range(0, 9) == 0));
        drain();
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        reset_step(1'b0, 1'b1);
        step(1'b1, 8'h9D, 1'b0, 1'b0);
        step(1'b1, 8'h9E, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
